// File: rtl/config_frame_writer.sv
// Config frame writer: receives header/data/checksum word frames from the
// upstream JTAG config stage, stages data words, and commits them (or a zero
// range) into the active register bank only when the checksum matches.
module config_frame_writer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    cfg_reset_in,
  input  logic                                    strobe_in,
  input  logic [31:0]                             word_in,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rd_addr,
  output logic [31:0]                             rd_data,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err,
  output logic [1:0]                              err_code,
  output logic [7:0]                              frame_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, CKSUM} state_t;

  localparam logic [1:0] E_HDR   = 2'b00;
  localparam logic [1:0] E_RANGE = 2'b01;
  localparam logic [1:0] E_CKSUM = 2'b10;
  localparam logic [1:0] E_TOUT  = 2'b11;

  state_t        state_q, state_d;
  logic          done_d, err_d;
  logic [1:0]    code_d;
  logic          accept_hdr, data_wr, commit;

  logic [31:0]   cksum_q;
  logic [TW-1:0] tcnt_q;
  logic [7:0]    s_q, n_q, k_q;
  logic          is_clear_q;

  logic [31:0]   active  [DEPTH];
  logic [31:0]   staging [DEPTH];

  // Header field decode
  logic       hdr_fmt_ok, hdr_range_ok, hdr_is_write;
  logic [8:0] hdr_end;
  logic [8:0] frame_end;
  logic [8:0] stg_sum;
  logic [AW-1:0] stg_idx;
  logic       timeout_hit;

  assign hdr_is_write = (word_in[23:20] == 4'd1);
  assign hdr_fmt_ok   = (word_in[31:24] == 8'hC5) &&
                        (hdr_is_write || (word_in[23:20] == 4'd2));
  assign hdr_end      = {1'b0, word_in[15:8]} + {1'b0, word_in[7:0]};
  assign hdr_range_ok = (word_in[7:0] != 8'd0) && (hdr_end <= 9'(DEPTH));
  assign frame_end    = {1'b0, s_q} + {1'b0, n_q};
  assign stg_sum      = {1'b0, s_q} + {1'b0, k_q};
  assign stg_idx      = stg_sum[AW-1:0];
  assign timeout_hit  = (tcnt_q == TW'(TIMEOUT - 1));
  assign busy         = (state_q != IDLE);

  // Next-state and decision logic
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    code_d     = err_code;
    accept_hdr = 1'b0;
    data_wr    = 1'b0;
    commit     = 1'b0;
    if (cfg_reset_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (strobe_in) begin
            if (!hdr_fmt_ok) begin
              err_d  = 1'b1;
              code_d = E_HDR;
            end else if (!hdr_range_ok) begin
              err_d  = 1'b1;
              code_d = E_RANGE;
            end else begin
              accept_hdr = 1'b1;
              state_d    = hdr_is_write ? DATA : CKSUM;
            end
          end
        end
        DATA: begin
          if (strobe_in) begin
            data_wr = 1'b1;
            if (k_q == n_q - 8'd1) state_d = CKSUM;
          end else if (timeout_hit) begin
            err_d   = 1'b1;
            code_d  = E_TOUT;
            state_d = IDLE;
          end
        end
        CKSUM: begin
          if (strobe_in) begin
            state_d = IDLE;
            if (word_in == cksum_q) begin
              commit = 1'b1;
              done_d = 1'b1;
            end else begin
              err_d  = 1'b1;
              code_d = E_CKSUM;
            end
          end else if (timeout_hit) begin
            err_d   = 1'b1;
            code_d  = E_TOUT;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= E_HDR;
    end else begin
      state_q  <= state_d;
      done     <= done_d;
      err      <= err_d;
      err_code <= code_d;
    end
  end

  // Frame context, checksum, timeout counter, active bank and read port
  always_ff @(posedge clk) begin
    if (reset) begin
      cksum_q    <= '0;
      tcnt_q     <= '0;
      s_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      is_clear_q <= 1'b0;
      frame_cnt  <= '0;
      rd_data    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) active[i] <= '0;
    end else begin
      rd_data <= active[rd_addr];
      if (state_q == IDLE || strobe_in || cfg_reset_in) tcnt_q <= '0;
      else                                              tcnt_q <= tcnt_q + 1'b1;
      if (accept_hdr) begin
        s_q        <= word_in[15:8];
        n_q        <= word_in[7:0];
        k_q        <= '0;
        is_clear_q <= !hdr_is_write;
        cksum_q    <= word_in;
      end
      if (data_wr) begin
        cksum_q <= cksum_q ^ word_in;
        k_q     <= k_q + 8'd1;
      end
      if (commit) begin
        frame_cnt <= frame_cnt + 8'd1;
        // Whole-range copy in one cycle: each entry decides independently
        // whether it lies inside [S, S+N).
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (9'(i) >= {1'b0, s_q} && 9'(i) < frame_end)
            active[i] <= is_clear_q ? '0 : staging[i];
        end
      end
    end
  end

  // Staging bank; contents only matter between header and commit
  always_ff @(posedge clk) begin
    if (data_wr) staging[stg_idx] <= word_in;
  end

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer: a DEPTH=16 instance for the
// frame/error/timeout/abort scenarios and a DEPTH=256 instance for the
// long back-to-back frame.
module tb_config_frame_writer;

  logic        clk = 1'b0;
  logic        reset;

  logic        cfg_reset_in, strobe_in;
  logic [31:0] word_in;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [7:0]  frame_cnt;

  logic        cfg_reset2, strobe2;
  logic [31:0] word2;
  logic [7:0]  rd_addr2;
  logic [31:0] rd_data2;
  logic        busy2, done2, err2;
  logic [1:0]  err_code2;
  logic [7:0]  frame_cnt2;

  int tests = 0;
  int fails = 0;
  int done2_cnt = 0;
  int err_seen;
  logic [31:0] x;

  always #5 clk = ~clk;

  config_frame_writer #(.DEPTH(16), .TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset), .cfg_reset_in(cfg_reset_in),
    .strobe_in(strobe_in), .word_in(word_in), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .frame_cnt(frame_cnt)
  );

  config_frame_writer #(.DEPTH(256), .TIMEOUT(1024)) dut256 (
    .clk(clk), .reset(reset), .cfg_reset_in(cfg_reset2),
    .strobe_in(strobe2), .word_in(word2), .rd_addr(rd_addr2),
    .rd_data(rd_data2), .busy(busy2), .done(done2), .err(err2),
    .err_code(err_code2), .frame_cnt(frame_cnt2)
  );

  always @(negedge clk) if (done2) done2_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    strobe_in = 1'b1;
    word_in   = w;
    tick();
    strobe_in = 1'b0;
    word_in   = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  function automatic logic [31:0] pat(input int unsigned k);
    return 32'h5A00_0000 ^ (k * 32'h0001_0103) ^ 32'h0000_00C3;
  endfunction

  initial begin
    logic [31:0] d;
    reset = 1'b1; cfg_reset_in = 1'b0; strobe_in = 1'b0; word_in = '0; rd_addr = '0;
    cfg_reset2 = 1'b0; strobe2 = 1'b0; word2 = '0; rd_addr2 = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_rd_data", rd_data, 0);

    // Checksum mismatch
    send(32'hC510_0202);
    check("hdr_busy", busy, 1);
    send(32'h1111_1111);
    send(32'h2222_2222);
    send(32'hF623_3130);
    check("bad_ck_err", err, 1);
    check("bad_ck_code", err_code, 2'b10);
    check("bad_ck_done", done, 0);
    check("bad_ck_busy", busy, 0);
    rd(4'd2, d); check("bad_ck_rd2", d, 0);
    check("bad_ck_cnt", frame_cnt, 0);

    // Good WRITE frame; read in commit cycle returns old data
    send(32'hC510_0202);
    send(32'h1111_1111);
    send(32'h2222_2222);
    rd_addr = 4'd2;
    send(32'hF623_3131);
    check("wr_done", done, 1);
    check("wr_err", err, 0);
    check("wr_precommit_rd", rd_data, 0);
    tick();
    check("wr_done_once", done, 0);
    rd(4'd2, d); check("wr_rd2", d, 32'h1111_1111);
    rd(4'd3, d); check("wr_rd3", d, 32'h2222_2222);
    rd(4'd4, d); check("wr_rd4", d, 0);
    check("wr_cnt", frame_cnt, 1);
    check("wr_code_held", err_code, 2'b10);

    // CLEAR frame on address 3 only
    send(32'hC520_0301);
    check("clr_busy", busy, 1);
    send(32'hC520_0301);
    check("clr_done", done, 1);
    rd(4'd3, d); check("clr_rd3", d, 0);
    rd(4'd2, d); check("clr_rd2", d, 32'h1111_1111);
    check("clr_cnt", frame_cnt, 2);

    // Header rejects
    send(32'hC510_0F02);
    check("range_err", err, 1);
    check("range_code", err_code, 2'b01);
    check("range_busy", busy, 0);
    send(32'hC510_0E02);
    check("edge_ok_busy", busy, 1);
    cfg_reset_in = 1'b1; tick(); cfg_reset_in = 1'b0;
    send(32'hC510_0200);
    check("zero_len_code", err_code, 2'b01);
    check("zero_len_err", err, 1);
    send(32'hA510_0202);
    check("sync_err", err, 1);
    check("sync_code", err_code, 2'b00);
    check("sync_busy", busy, 0);
    send(32'hC530_0202);
    check("opc_err", err, 1);
    check("opc_code", err_code, 2'b00);

    // Timeout: err exactly after 1024 idle cycles
    send(32'hC510_0202);
    err_seen = 0;
    for (int i = 0; i < 1023; i++) begin
      tick();
      if (err) err_seen = 1;
    end
    check("tout_early", err_seen, 0);
    check("tout_busy_before", busy, 1);
    tick();
    check("tout_err", err, 1);
    check("tout_code", err_code, 2'b11);
    check("tout_busy", busy, 0);

    // Abort mid-DATA with coincident strobe
    send(32'hC510_0202);
    send(32'h3333_3333);
    cfg_reset_in = 1'b1;
    send(32'h4444_4444);
    cfg_reset_in = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_err", err, 0);
    check("abort_done", done, 0);
    tick();
    check("abort_err_late", err, 0);
    rd(4'd2, d); check("abort_rd2", d, 32'h1111_1111);
    rd(4'd3, d); check("abort_rd3", d, 0);
    check("abort_cnt", frame_cnt, 2);

    // DEPTH=256 back-to-back 255-word frame
    x = 32'hC510_00FF;
    strobe2 = 1'b1; word2 = 32'hC510_00FF;
    tick();
    for (int unsigned k = 0; k < 255; k++) begin
      word2 = pat(k);
      x = x ^ pat(k);
      tick();
    end
    word2 = x;
    tick();
    strobe2 = 1'b0; word2 = '0;
    check("big_done", done2, 1);
    tick(); tick();
    check("big_done_once", done2_cnt, 1);
    check("big_err", err2, 0);
    check("big_cnt", frame_cnt2, 1);
    rd_addr2 = 8'd0;   tick(); check("big_rd0", rd_data2, pat(0));
    rd_addr2 = 8'd127; tick(); check("big_rd127", rd_data2, pat(127));
    rd_addr2 = 8'd254; tick(); check("big_rd254", rd_data2, pat(254));
    rd_addr2 = 8'd255; tick(); check("big_rd255", rd_data2, 0);

    // Reset mid-frame: discarded silently
    send(32'hC510_0202);
    send(32'h5555_5555);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_done", done, 0);
    check("midrst_cnt", frame_cnt, 0);
    tick();
    check("midrst_err_late", err, 0);
    rd(4'd2, d); check("midrst_rd2", d, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/config_frame_writer.md
CONFIG_FRAME_WRITER -- requirements
Module: config_frame_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 32-bit config words in the active bank (power of two, max 256).
REQ-002 SHALL have parameter TIMEOUT, default 1024, idle clk cycles allowed between strobes inside a frame.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_reset_in  input  1  abort request from the upstream JTAG config stage (its resetOut).
REQ-006 SHALL have port strobe_in  input  1  one-cycle pulse; word_in is valid.
REQ-007 SHALL have port word_in  input  32  config word from the upstream stage.
REQ-008 SHALL have port rd_addr  input  log2(DEPTH)  active-bank read address.
REQ-009 SHALL have port rd_data  output  32  registered active-bank read data.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress (state != IDLE).
REQ-011 SHALL have port done  output  1  one-cycle pulse: frame committed.
REQ-012 SHALL have port err  output  1  one-cycle pulse: frame rejected.
REQ-013 SHALL have port err_code  output  2  cause of the last err; held until the next err.
REQ-014 SHALL have port frame_cnt  output  8  count of committed frames; wraps 255->0.

Function
REQ-015 Header word SHALL be: [31:24] sync 8'hC5; [23:20] opcode (1 = WRITE, 2 = CLEAR); [19:16] ignored; [15:8] start address S; [7:0] length N.
REQ-016 States SHALL be IDLE, DATA, CKSUM; a strobe in IDLE is a header.
REQ-017 In IDLE, a header with a bad sync byte or an unknown opcode SHALL pulse err with err_code 00 and remain in IDLE.
REQ-018 In IDLE, a header with N = 0 or S+N > DEPTH (9-bit compare) SHALL pulse err with err_code 01 and remain in IDLE.
REQ-019 A valid WRITE header SHALL go to DATA; a valid CLEAR header SHALL go to CKSUM.
REQ-020 Running checksum SHALL be the XOR of the header and all data words, initialised with the header.
REQ-021 In DATA, the k-th strobe (k = 0..N-1) SHALL store word_in into staging[S+k]; after the N-th data word, go to CKSUM.
REQ-022 In CKSUM, a strobe with word_in equal to the running XOR SHALL commit in that cycle, return to IDLE and pulse done the next cycle.
REQ-023 Commit SHALL copy staging[S..S+N-1] to active[S..S+N-1] for WRITE, or write zeros to that range for CLEAR; other entries are untouched.
REQ-024 A checksum mismatch SHALL pulse err with err_code 10, return to IDLE, and leave the active bank unchanged.
REQ-025 frame_cnt SHALL increment on each commit.
REQ-026 In DATA or CKSUM, a timeout counter SHALL clear on each strobe; reaching TIMEOUT SHALL pulse err with err_code 11 and return to IDLE without commit.
REQ-027 cfg_reset_in = 1 SHALL force IDLE in that cycle, ignore any coincident strobe, skip commit, raise no err, and leave the active bank and frame_cnt unchanged.
REQ-028 Priority SHALL be reset > cfg_reset_in > strobe_in > timeout.
REQ-029 done and err SHALL be registered, one cycle after the deciding strobe or timeout, and never high together.
REQ-030 rd_data SHALL equal active[rd_addr] one cycle after rd_addr is sampled; a read in the commit cycle returns pre-commit data.
REQ-031 Back-to-back strobes on consecutive cycles SHALL all be accepted; there is no backpressure.

Reset
REQ-032 On reset the block SHALL set state IDLE, busy 0, done 0, err 0, err_code 00, frame_cnt 0, rd_data 0, running checksum 0 and timeout counter 0.
REQ-033 On reset the block SHALL clear every active-bank entry to 0; staging contents are don't-care.
REQ-034 A reset mid-frame SHALL discard the frame with no done or err pulse.

Verification
REQ-035 WRITE frame C5100202, 11111111, 22222222, F6233131 -> done once; rd_addr 2 and 3 read 11111111 and 22222222; frame_cnt = 1.
REQ-036 Same frame with checksum F6233130 -> err with err_code 10; rd_addr 2 reads 0; frame_cnt = 0.
REQ-037 Header C5100F02 (DEPTH 16) -> err with err_code 01, busy stays 0; header A5100202 -> err with err_code 00.
REQ-038 After REQ-035, CLEAR frame C5200301 then checksum C5200301 -> done; rd_addr 3 reads 0 and rd_addr 2 still reads 11111111.
REQ-039 WRITE header with no further strobes for 1024 cycles -> err with err_code 11 and busy falls; then cfg_reset_in mid-DATA of a second frame -> busy falls, no err, active bank unchanged.
REQ-040 WRITE frame C51000FF to DEPTH 256 with strobes on consecutive cycles -> all 255 words committed and done pulses once.
